// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel pixel return path: pixel constants,
// UART transmitter FSM states and a constant-width helper.
package sobel_pkg;

  localparam logic [15:0] BLACK = '0;
  localparam logic [15:0] WHITE = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Bits needed to count 0..value-1 (at least 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < value; i = i << 1) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pix_sync_fifo.sv
// Single-clock pixel FIFO with registered read data (valid the clock after rd_en).
// Pointers carry one extra MSB so full and empty are distinguishable.
module pix_sync_fifo
  import sobel_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 64
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_ff @(posedge sys_clk) begin
    if (wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/sobel_pix_uart_tx.sv
// Buffers 16-bit Sobel pixels and sends each as two UART 8N1 bytes, high byte first.
module sobel_pix_uart_tx
  import sobel_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned UART_BPS   = 9600,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        pi_flag,
  input  logic [15:0] pi_data,
  output logic        tx,
  output logic        tx_busy,
  output logic        fifo_full,
  output logic        ovf_err
);

  localparam int unsigned   BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int unsigned   BW           = clog2(BAUD_CNT_MAX);
  localparam logic [BW-1:0] BAUD_LAST    = BW'(BAUD_CNT_MAX - 1);

  tx_state_t     state;
  tx_state_t     state_nxt;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic          byte_sel;
  logic [15:0]   pix_reg;
  logic [15:0]   pix_word;
  logic [7:0]    shift_reg;
  logic          tx_reg;
  logic          busy_reg;
  logic          ovf_reg;
  logic          baud_done;
  logic          fifo_rd_en;
  logic          fifo_empty;
  logic [15:0]   fifo_rd_data;

  pix_sync_fifo #(
    .WIDTH(16),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .wr_en    (pi_flag),
    .wr_data  (pi_data),
    .rd_en    (fifo_rd_en),
    .rd_data  (fifo_rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign baud_done = (baud_cnt == BAUD_LAST);
  // The popped word only lands on rd_data in LOAD, so the high byte is taken
  // straight from the FIFO and pix_reg is captured there for the low byte.
  assign pix_word  = byte_sel ? pix_reg : fifo_rd_data;

  assign tx      = tx_reg;
  assign tx_busy = busy_reg;
  assign ovf_err = ovf_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_nxt  = LOAD;
        end
      end
      LOAD:  state_nxt = START;
      START: if (baud_done) state_nxt = DATA;
      DATA:  if (baud_done && bit_cnt == 3'd7) state_nxt = STOP;
      STOP: begin
        if (baud_done) begin
          if (!byte_sel) begin
            state_nxt = LOAD;
          end else if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            state_nxt  = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_sel  <= 1'b0;
      pix_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      busy_reg <= (state != IDLE) | ~fifo_empty;
      if (pi_flag && fifo_full) begin
        ovf_reg <= 1'b1;
      end
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          tx_reg   <= 1'b1;
          if (!fifo_empty) begin
            byte_sel <= 1'b0;
          end
        end
        LOAD: begin
          baud_cnt  <= '0;
          tx_reg    <= 1'b0;
          shift_reg <= byte_sel ? pix_word[7:0] : pix_word[15:8];
          if (!byte_sel) begin
            pix_reg <= fifo_rd_data;
          end
        end
        START: begin
          baud_cnt <= baud_done ? '0 : baud_cnt + BW'(1);
          if (baud_done) begin
            bit_cnt <= '0;
            tx_reg  <= shift_reg[0];
          end
        end
        DATA: begin
          baud_cnt <= baud_done ? '0 : baud_cnt + BW'(1);
          if (baud_done) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              tx_reg <= 1'b1;
            end else begin
              tx_reg    <= shift_reg[1];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end
        end
        STOP: begin
          baud_cnt <= baud_done ? '0 : baud_cnt + BW'(1);
          tx_reg   <= 1'b1;
          if (baud_done) begin
            if (!byte_sel) begin
              byte_sel <= 1'b1;
            end else if (!fifo_empty) begin
              byte_sel <= 1'b0;
            end
          end
        end
        default: tx_reg <= 1'b1;
      endcase
    end
  end

endmodule
